slot_count_gen: RTL and testbench

- Free-running/one-shot sequencer that produces the 8-bit `count` consumed by the slot address decoder.
- Steps `count` from 0 to COUNT_MAX at a prescaled rate.
- Tracks the current 13-count slot and its index, and reports run status with a start/stop/done handshake.
- Sits between the top-level control logic and the address decoder / message ROM path.

---
 rtl/slot_count_gen.sv | 129 ++++++++++++
 tb/tb_slot_count_gen.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/slot_count_gen.sv
// slot_count_gen
// Sequencer that steps the 8-bit count fed to the slot address decoder from
// 0 to COUNT_MAX, one step every PRESCALE clocks. It also tracks which
// SLOT_LEN-long slot the count is in and reports run status.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   start       begin a sequence when idle (ignored while running)
//   stop        abort a running sequence; wins over a coincident step
//   loop        wrap to 0 after COUNT_MAX instead of finishing (sampled at wrap)
//   count       current count value
//   slot        floor(count / SLOT_LEN) mod 16, tracked incrementally
//   slot_strobe one-cycle pulse on the edge a new slot begins
//   busy        high while running
//   done        one-cycle pulse when a non-looping sequence completes
module slot_count_gen #(
  parameter int unsigned PRESCALE  = 1,
  parameter int unsigned COUNT_MAX = 197,
  parameter int unsigned SLOT_LEN  = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  output logic [7:0] count,
  output logic [3:0] slot,
  output logic       slot_strobe,
  output logic       busy,
  output logic       done
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned SW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] POS_LAST   = SW'(SLOT_LEN - 1);
  localparam logic [7:0]    CMAX       = 8'(COUNT_MAX);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [SW-1:0] pos, pos_n;
  logic [7:0]    count_n;
  logic [3:0]    slot_n;
  logic          strobe_n, busy_n, done_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      presc       <= '0;
      pos         <= '0;
      count       <= '0;
      slot        <= '0;
      slot_strobe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      presc       <= presc_n;
      pos         <= pos_n;
      count       <= count_n;
      slot        <= slot_n;
      slot_strobe <= strobe_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    presc_n  = presc;
    pos_n    = pos;
    count_n  = count;
    slot_n   = slot;
    strobe_n = 1'b0;
    busy_n   = busy;
    done_n   = 1'b0;

    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          state_n  = RUN;
          presc_n  = '0;
          pos_n    = '0;
          count_n  = '0;
          slot_n   = '0;
          strobe_n = 1'b1;
          busy_n   = 1'b1;
        end
      end

      RUN: begin
        if (stop) begin
          // Abort freezes count/slot/position where they are.
          state_n = IDLE;
          busy_n  = 1'b0;
        end else if (presc != PRESC_LAST) begin
          presc_n = presc + PW'(1);
        end else begin
          presc_n = '0;
          if (count < CMAX) begin
            count_n = count + 8'd1;
            if (pos == POS_LAST) begin
              pos_n    = '0;
              slot_n   = slot + 4'd1;
              strobe_n = 1'b1;
            end else begin
              pos_n = pos + SW'(1);
            end
          end else if (loop) begin
            count_n  = '0;
            slot_n   = '0;
            pos_n    = '0;
            strobe_n = 1'b1;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_slot_count_gen.sv
module tb_slot_count_gen;

  typedef struct packed {
    logic [7:0] count;
    logic [3:0] slot;
    logic       strobe;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct {
    logic s;
    logic p;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic start4 = 1'b0, stop4 = 1'b0, loop4 = 1'b0;

  logic [7:0] count, count4;
  logic [3:0] slot, slot4;
  logic       strobe, strobe4, busy, busy4, done, done4;

  exp_t act, act4;
  assign act  = {count, slot, strobe, busy, done};
  assign act4 = {count4, slot4, strobe4, busy4, done4};

  exp_t sbq[$];
  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  slot_count_gen dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
    .count(count), .slot(slot), .slot_strobe(strobe), .busy(busy), .done(done)
  );

  slot_count_gen #(.PRESCALE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .stop(stop4), .loop(loop4),
    .count(count4), .slot(slot4), .slot_strobe(strobe4), .busy(busy4), .done(done4)
  );

  function automatic exp_t mk(input int unsigned c, input int unsigned sl,
                              input logic st, input logic b, input logic d);
    exp_t e;
    e.count  = 8'(c);
    e.slot   = 4'(sl);
    e.strobe = st;
    e.busy   = b;
    e.done   = d;
    return e;
  endfunction

  // Expected outputs k steps after a start edge (PRESCALE=1).
  function automatic exp_t run_exp(input int unsigned k);
    return mk(k, (k / 13) % 16, (k % 13) == 0, 1'b1, 1'b0);
  endfunction

  // Expected outputs n clocks after a start edge with PRESCALE=4.
  function automatic exp_t p4_exp(input int unsigned n);
    int unsigned c;
    c = n / 4;
    return mk(c, (c / 13) % 16, ((n % 4) == 0) && ((c % 13) == 0), 1'b1, 1'b0);
  endfunction

  task automatic chk(input string nm, input exp_t e, input exp_t a);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got count=%0d slot=%0d strobe=%b busy=%b done=%b, want count=%0d slot=%0d strobe=%b busy=%b done=%b",
               nm, a.count, a.slot, a.strobe, a.busy, a.done,
               e.count, e.slot, e.strobe, e.busy, e.done);
    end
  endtask

  // Drive one cycle of inputs to the selected DUT, queue the expectation,
  // and compare it against the outputs after the edge.
  task automatic cyc(input logic sel, input logic s, input logic p, input logic l,
                     input exp_t e, input string nm);
    exp_t x;
    if (!sel) begin
      start = s; stop = p; loop = l;
      start4 = 1'b0; stop4 = 1'b0; loop4 = 1'b0;
    end else begin
      start4 = s; stop4 = p; loop4 = l;
      start = 1'b0; stop = 1'b0; loop = 1'b0;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    chk(nm, x, sel ? act4 : act);
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{s: 1'b0, p: 1'b0, e: mk(0, 0, 0, 0, 0)};
    tbl[1]  = '{s: 1'b1, p: 1'b1, e: mk(0, 0, 0, 0, 0)};
    tbl[2]  = '{s: 1'b1, p: 1'b0, e: mk(0, 0, 1, 1, 0)};
    tbl[3]  = '{s: 1'b0, p: 1'b0, e: mk(1, 0, 0, 1, 0)};
    tbl[4]  = '{s: 1'b0, p: 1'b0, e: mk(2, 0, 0, 1, 0)};
    tbl[5]  = '{s: 1'b0, p: 1'b1, e: mk(2, 0, 0, 0, 0)};
    tbl[6]  = '{s: 1'b0, p: 1'b0, e: mk(2, 0, 0, 0, 0)};
    tbl[7]  = '{s: 1'b1, p: 1'b1, e: mk(2, 0, 0, 0, 0)};
    tbl[8]  = '{s: 1'b0, p: 1'b1, e: mk(2, 0, 0, 0, 0)};
    tbl[9]  = '{s: 1'b1, p: 1'b0, e: mk(0, 0, 1, 1, 0)};
    tbl[10] = '{s: 1'b0, p: 1'b1, e: mk(0, 0, 0, 0, 0)};

    // Asynchronous reset takes effect between edges.
    #2 rst = 1'b1;
    #1;
    chk("reset", mk(0, 0, 0, 0, 0), act);
    chk("reset_p4", mk(0, 0, 0, 0, 0), act4);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 11; i++)
      cyc(1'b0, tbl[i].s, tbl[i].p, 1'b0, tbl[i].e, $sformatf("table_%0d", i));

    // Full one-shot run; start re-asserted mid-run must not restart.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, run_exp(0), "run_e0");
    for (int k = 1; k <= 197; k++)
      cyc(1'b0, (k >= 100 && k <= 102), 1'b0, 1'b0, run_exp(k), $sformatf("run_e%0d", k));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, mk(197, 15, 0, 0, 1), "run_done");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, mk(197, 15, 0, 0, 0), "run_done_clear");

    // Looping run, loop dropped during the second pass.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, run_exp(0), "loop_e0");
    for (int k = 1; k <= 395; k++)
      cyc(1'b0, 1'b0, 1'b0, (k <= 298), run_exp(k % 198), $sformatf("loop_e%0d", k));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, mk(197, 15, 0, 0, 1), "loop_done");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, mk(197, 15, 0, 0, 0), "loop_done_clear");

    // Stop on the edge that would step 50 -> 51.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, run_exp(0), "stop_e0");
    for (int k = 1; k <= 50; k++)
      cyc(1'b0, 1'b0, 1'b0, 1'b0, run_exp(k), $sformatf("stop_e%0d", k));
    cyc(1'b0, 1'b0, 1'b1, 1'b0, mk(50, 3, 0, 0, 0), "stop_at_50");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, mk(50, 3, 0, 0, 0), "stop_hold");

    // Restart, then asynchronous reset mid-run at count 120.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, run_exp(0), "restart_e0");
    for (int k = 1; k <= 120; k++)
      cyc(1'b0, 1'b0, 1'b0, 1'b0, run_exp(k), $sformatf("restart_e%0d", k));
    #2 rst = 1'b1;
    #1;
    chk("async_rst", mk(0, 0, 0, 0, 0), act);
    #1 rst = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, run_exp(0), "post_rst_start");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, run_exp(1), "post_rst_step");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, mk(1, 0, 0, 0, 0), "post_rst_stop");

    // PRESCALE=4 instance: one step every 4 clocks, done at E792.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, p4_exp(0), "p4_e0");
    for (int n = 1; n <= 791; n++)
      cyc(1'b1, 1'b0, 1'b0, 1'b0, p4_exp(n), $sformatf("p4_e%0d", n));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, mk(197, 15, 0, 0, 1), "p4_done");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, mk(197, 15, 0, 0, 0), "p4_done_clear");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
